lsu_axi_master: RTL and testbench
=================================

Name: lsu_axi_master

Overview:
- AXI4-Lite initiator on the LSU side of the core; the far end of the LSU SRAM read/write responder.
- Accepts one load or store request at a time from EXU via valid/ready.
- Drives AR/R or AW/W/B, performs byte-lane steering and sign/zero extension, and returns one response per request to WBU via valid/ready.

Parameters:
- RESP_OKAY, 2'b00, bresp/rresp value treated as success; any other value sets resp_err.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  EXU request valid
- req_ready  out  1  block idle, able to accept a request
- req_wen  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (LSB = byte at addr)
- req_size  in  2  0=byte, 1=half, 2=word; 3 is illegal
- req_unsigned  in  1  load zero-extend when 1, sign-extend when 0
- resp_valid  out  1  response valid
- resp_ready  in  1  WBU accepts response
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  bus error, misaligned access, or illegal size
- m_araddr / m_arvalid / m_arready  out 32 / out 1 / in 1  read address channel
- m_rdata / m_rresp / m_rvalid / m_rready  in 32 / in 2 / in 1 / out 1  read data channel
- m_awaddr / m_awvalid / m_awready  out 32 / out 1 / in 1  write address channel
- m_wdata / m_wstrb / m_wvalid / m_wready  out 32 / out 4 / out 1 / in 1  write data channel
- m_bresp / m_bvalid / m_bready  in 2 / in 1 / out 1  write response channel

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP. Reset forces IDLE, clears all latched fields; resp_rdata=0, resp_err=0.
- All valid/ready outputs decode from registered state/flags only; after reset all are 0 except req_ready=1.
- IDLE: req_ready=1. On req_valid: latch wen, addr, wdata, size, unsigned.
  - Misaligned (half with addr[0]=1; word with addr[1:0]!=0) or size=3: next state RESP, resp_err=1, no bus traffic.
  - Otherwise: next state RD_ADDR (load) or WR_REQ (store).
- RD_ADDR: m_arvalid=1; m_araddr={addr[31:2],2'b00}, held stable until m_arready. On handshake -> RD_DATA.
- RD_DATA: m_rready=1. On m_rvalid:
  - Shift m_rdata right by 8*addr[1:0], then extend per size/unsigned (byte from bit 7, half from bit 15, word unchanged).
  - Register result into resp_rdata; resp_err=(m_rresp!=RESP_OKAY); -> RESP.
  - m_rvalid in any other state is ignored.
- WR_REQ: m_awvalid and m_wvalid both asserted on entry.
  - m_awaddr={addr[31:2],2'b00}; m_wdata=wdata<<(8*addr[1:0]).
  - m_wstrb: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
  - Each valid drops the cycle after its own handshake, independently; same-cycle handshakes drop both together.
  - When both handshakes are done -> WR_RESP.
- WR_RESP: m_bready=1. On m_bvalid: resp_err=(m_bresp!=RESP_OKAY), resp_rdata=0 -> RESP.
- RESP: resp_valid=1, outputs held until resp_ready; then IDLE. req_ready=0 in RESP, so a new request is accepted no earlier than the cycle after the response handshake.
- One outstanding transaction; no pipelining.
- Minimum load latency: accept at cycle 0, AR handshake cycle 1, R handshake cycle 2, resp_valid cycle 3.
- Reset mid-transaction: abandon; all AXI valids and resp_valid are 0 from the next cycle. Reset is system-wide, so the slave resets too.
- AXI rule: no valid deasserts before its handshake; address/data held stable while valid.

Test Plan:
- LW addr 0x80000004, slave arready=1, rdata 0xDEADBEEF after 1 cycle → araddr 0x80000004; resp_valid at cycle 3; resp_rdata 0xDEADBEEF; err=0.
- LB signed addr 0x80000003, rdata 0x80FF_1234 → resp_rdata 0xFFFFFF80. LHU addr 0x80000002, same rdata → resp_rdata 0x000080FF.
- SB addr 0x80000001, wdata 0x000000AB → awaddr 0x80000000, wdata 0x0000AB00, wstrb 4'b0010. awready 3 cycles before wready: awvalid drops first, wvalid held; bresp OKAY → resp_err=0.
- SW addr 0x80000006 → no AR/AW activity; resp_valid next cycle with resp_err=1. Load with rresp=2'b10 → resp_err=1.
- resp_ready held low 4 cycles: resp_valid/resp_rdata stable, req_ready=0, second req_valid not accepted until after the response handshake.
- Assert rst while in RD_DATA → m_rready, m_arvalid, resp_valid all 0 the next cycle; req_ready=1; following LW completes normally.

Source files
------------

// File: rtl/lsu_axi_master.sv
// LSU-side AXI4-Lite initiator: one load/store at a time from EXU, byte-lane
// steering and load extension, one response per request back to WBU.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | req_ready high, waiting for an EXU request
// RD_ADDR | m_arvalid high, waiting for m_arready
// RD_DATA | m_rready high, waiting for m_rvalid
// WR_REQ  | AW and W offered independently until both have handshaken
// WR_RESP | m_bready high, waiting for m_bvalid
// RESP    | resp_valid high, holding the response until resp_ready
module lsu_axi_master #(
  parameter logic [1:0] RESP_OKAY = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;

  state_t      state, state_n;
  logic        wen_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        aw_done, w_done;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        misaligned;
  logic [4:0]  shamt;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;
  logic        aw_hs, w_hs;

  assign misaligned = (req_size == 2'd3) ||
                      (req_size == 2'd1 && req_addr[0]) ||
                      (req_size == 2'd2 && req_addr[1:0] != 2'b00);
  assign shamt      = {addr_q[1:0], 3'b000};
  assign rd_shift   = m_rdata >> shamt;
  assign aw_hs      = m_awvalid & m_awready;
  assign w_hs       = m_wvalid & m_wready;

  assign m_araddr   = {addr_q[31:2], 2'b00};
  assign m_awaddr   = {addr_q[31:2], 2'b00};
  assign m_wdata    = wdata_q << shamt;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  // Load extension: byte/half sign comes from bit 7/15 of the lane-shifted data
  always_comb begin
    rd_ext = rd_shift;
    case (size_q)
      2'd0:    rd_ext = {{24{~uns_q & rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    rd_ext = {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  // Store byte strobes follow the access size and low address bits
  always_comb begin
    m_wstrb = 4'b1111;
    case (size_q)
      2'd0:    m_wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    m_wstrb = 4'b0011 << addr_q[1:0];
      default: m_wstrb = 4'b1111;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and handshake outputs; all valids/readies decode from registers only
  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    m_awvalid  = 1'b0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned)   state_n = RESP;
          else if (req_wen) state_n = WR_REQ;
          else              state_n = RD_ADDR;
        end
      end
      RD_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_n = RD_DATA;
      end
      RD_DATA: begin
        m_rready = 1'b1;
        if (m_rvalid) state_n = RESP;
      end
      WR_REQ: begin
        m_awvalid = ~aw_done;
        m_wvalid  = ~w_done;
        if ((aw_done | (~aw_done & m_awready)) && (w_done | (~w_done & m_wready)))
          state_n = WR_RESP;
      end
      WR_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) state_n = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request latch, write-channel progress flags and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          wen_q   <= req_wen;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          size_q  <= req_size;
          uns_q   <= req_unsigned;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          rdata_q <= '0;
          err_q   <= misaligned;
        end
        RD_DATA: if (m_rvalid) begin
          rdata_q <= rd_ext;
          err_q   <= (m_rresp != RESP_OKAY);
        end
        WR_REQ: begin
          aw_done <= aw_done | aw_hs;
          w_done  <= w_done | w_hs;
        end
        WR_RESP: if (m_bvalid) begin
          rdata_q <= '0;
          err_q   <= (m_bresp != RESP_OKAY);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: loads, stores, error paths, response
// backpressure and mid-transaction reset, with hand-computed expectations.
module tb_lsu_axi_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]  m_rresp, m_bresp;
  logic [3:0]  m_wstrb;

  int errors = 0;
  int checks = 0;

  lsu_axi_master #(.RESP_OKAY(2'b00)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] size, input logic uns);
    req_valid = 1'b1; req_wen = wen; req_addr = addr;
    req_wdata = wd; req_size = size; req_unsigned = uns;
  endtask

  // Full load with arready tied high and read data one cycle after AR
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] rd, input logic [1:0] rr,
                         input logic [31:0] exp_araddr, input logic [31:0] exp_data,
                         input logic exp_err);
    set_req(1'b0, addr, 32'h0, size, uns);
    chk({tag, ".req_ready"}, req_ready, 1);
    step();                                   // cycle 1: RD_ADDR
    req_valid = 1'b0;
    chk({tag, ".arvalid"}, m_arvalid, 1);
    chk({tag, ".araddr"}, m_araddr, exp_araddr);
    step();                                   // cycle 2: RD_DATA
    chk({tag, ".rready"}, m_rready, 1);
    chk({tag, ".arvalid_drop"}, m_arvalid, 0);
    m_rvalid = 1'b1; m_rdata = rd; m_rresp = rr;
    step();                                   // cycle 3: RESP
    m_rvalid = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00;
    chk({tag, ".resp_valid"}, resp_valid, 1);
    chk({tag, ".rdata"}, resp_rdata, exp_data);
    chk({tag, ".err"}, resp_err, exp_err);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk({tag, ".resp_done"}, resp_valid, 0);
    chk({tag, ".idle"}, req_ready, 1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0; resp_ready = 1'b0;
    m_arready = 1'b1; m_rdata = '0; m_rresp = '0; m_rvalid = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bresp = '0; m_bvalid = 1'b0;
    step(); step();
    rst = 1'b0;

    chk("rst.req_ready", req_ready, 1);
    chk("rst.arvalid", m_arvalid, 0);
    chk("rst.awvalid", m_awvalid, 0);
    chk("rst.wvalid", m_wvalid, 0);
    chk("rst.rready", m_rready, 0);
    chk("rst.bready", m_bready, 0);
    chk("rst.resp_valid", resp_valid, 0);
    chk("rst.resp_rdata", resp_rdata, 32'h0);
    chk("rst.resp_err", resp_err, 0);

    do_load("lw",  32'h8000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0);
    do_load("lb",  32'h8000_0003, 2'd0, 1'b0, 32'h80FF_1234, 2'b00, 32'h8000_0000, 32'hFFFF_FF80, 1'b0);
    do_load("lhu", 32'h8000_0002, 2'd1, 1'b1, 32'h80FF_1234, 2'b00, 32'h8000_0000, 32'h0000_80FF, 1'b0);
    do_load("lh",  32'h8000_0002, 2'd1, 1'b0, 32'h80FF_1234, 2'b00, 32'h8000_0000, 32'hFFFF_80FF, 1'b0);
    do_load("lbu", 32'h8000_0001, 2'd0, 1'b1, 32'h80FF_1234, 2'b00, 32'h8000_0000, 32'h0000_0012, 1'b0);
    do_load("lerr", 32'h8000_0008, 2'd2, 1'b0, 32'h1234_5678, 2'b10, 32'h8000_0008, 32'h1234_5678, 1'b1);

    // SB: AW accepted three cycles before W
    set_req(1'b1, 32'h8000_0001, 32'h0000_00AB, 2'd0, 1'b0);
    step();
    req_valid = 1'b0;
    chk("sb.awvalid", m_awvalid, 1);
    chk("sb.wvalid", m_wvalid, 1);
    chk("sb.awaddr", m_awaddr, 32'h8000_0000);
    chk("sb.wdata", m_wdata, 32'h0000_AB00);
    chk("sb.wstrb", m_wstrb, 4'b0010);
    m_awready = 1'b1;
    step();
    m_awready = 1'b0;
    chk("sb.aw_drop", m_awvalid, 0);
    chk("sb.w_hold1", m_wvalid, 1);
    step();
    chk("sb.w_hold2", m_wvalid, 1);
    step();
    chk("sb.w_hold3", m_wvalid, 1);
    chk("sb.wdata_stable", m_wdata, 32'h0000_AB00);
    m_wready = 1'b1;
    step();
    m_wready = 1'b0;
    chk("sb.w_drop", m_wvalid, 0);
    chk("sb.aw_still_low", m_awvalid, 0);
    chk("sb.bready", m_bready, 1);
    m_bvalid = 1'b1; m_bresp = 2'b00;
    step();
    m_bvalid = 1'b0;
    chk("sb.resp_valid", resp_valid, 1);
    chk("sb.err", resp_err, 0);
    chk("sb.rdata", resp_rdata, 32'h0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // SH: both handshakes in the same cycle, slave error response
    set_req(1'b1, 32'h8000_0002, 32'h0000_BEEF, 2'd1, 1'b0);
    step();
    req_valid = 1'b0;
    chk("sh.wdata", m_wdata, 32'hBEEF_0000);
    chk("sh.wstrb", m_wstrb, 4'b1100);
    m_awready = 1'b1; m_wready = 1'b1;
    step();
    m_awready = 1'b0; m_wready = 1'b0;
    chk("sh.aw_drop", m_awvalid, 0);
    chk("sh.w_drop", m_wvalid, 0);
    m_bvalid = 1'b1; m_bresp = 2'b10;
    step();
    m_bvalid = 1'b0; m_bresp = 2'b00;
    chk("sh.err", resp_err, 1);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // SW misaligned: straight to error response, no bus traffic
    set_req(1'b1, 32'h8000_0006, 32'h1111_2222, 2'd2, 1'b0);
    step();
    req_valid = 1'b0;
    chk("swmis.resp_valid", resp_valid, 1);
    chk("swmis.err", resp_err, 1);
    chk("swmis.awvalid", m_awvalid, 0);
    chk("swmis.wvalid", m_wvalid, 0);
    chk("swmis.arvalid", m_arvalid, 0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // Illegal size 3
    set_req(1'b0, 32'h8000_0000, 32'h0, 2'd3, 1'b0);
    step();
    req_valid = 1'b0;
    chk("size3.resp_valid", resp_valid, 1);
    chk("size3.err", resp_err, 1);
    chk("size3.arvalid", m_arvalid, 0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // Response backpressure with a second request waiting
    set_req(1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0);
    step();
    step();
    req_valid = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D;
    step();
    m_rvalid = 1'b0; m_rdata = 32'h0;
    set_req(1'b0, 32'h8000_0020, 32'h0, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("bp.resp_valid", resp_valid, 1);
      chk("bp.rdata", resp_rdata, 32'hCAFE_F00D);
      chk("bp.req_ready", req_ready, 0);
      chk("bp.arvalid", m_arvalid, 0);
      step();
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("bp.after_resp_idle", req_ready, 1);
    chk("bp.after_resp_arvalid", m_arvalid, 0);
    step();
    req_valid = 1'b0;
    chk("bp.second_arvalid", m_arvalid, 1);
    chk("bp.second_araddr", m_araddr, 32'h8000_0020);
    step();
    m_rvalid = 1'b1; m_rdata = 32'h0000_0042;
    step();
    m_rvalid = 1'b0; m_rdata = 32'h0;
    chk("bp.second_rdata", resp_rdata, 32'h0000_0042);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // Reset while waiting in RD_DATA
    set_req(1'b0, 32'h8000_0030, 32'h0, 2'd2, 1'b0);
    step();
    req_valid = 1'b0;
    step();
    chk("mrst.rready_before", m_rready, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst.rready", m_rready, 0);
    chk("mrst.arvalid", m_arvalid, 0);
    chk("mrst.resp_valid", resp_valid, 0);
    chk("mrst.req_ready", req_ready, 1);
    do_load("mrst.lw", 32'h8000_0004, 2'd2, 1'b0, 32'h0BAD_CAFE, 2'b00, 32'h8000_0004, 32'h0BAD_CAFE, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
